// File: rtl/if_stage.sv
// ============================================================================
// if_stage -- RV64 instruction-fetch stage, directly upstream of id_stage.
//
// Purpose:
//   Owns the fetch PC and keeps at most one request outstanding on the
//   instruction bus. Returned words are stored in a small FIFO together with
//   their PC and handed to id_stage with a valid/ready handshake. A redirect
//   flushes the FIFO and throws away any response that is still in flight.
//
// Ports:
//   clk, rst          clock (rising edge); asynchronous active-high reset
//   redirect_valid    flush and restart fetch at redirect_pc
//   redirect_pc[63:0] new fetch PC (bits [1:0] forced to zero)
//   imem_req_valid    fetch request valid
//   imem_req_ready    bus accepts the request this cycle
//   imem_req_addr     fetch address (the current PC)
//   imem_resp_valid   response word valid (in order, >=1 cycle after accept)
//   imem_resp_data    fetched instruction word
//   inst_valid        FIFO head valid toward id_stage
//   id_ready          id_stage consumes the head this cycle
//   inst, inst_addr   head instruction word and its PC (zero when empty)
// ============================================================================
module if_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        id_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_addr
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] addr;
    } fifo_ent_t;

    state_t          state_q, state_d;
    logic [63:0]     pc_q, pc_d;
    logic [63:0]     req_pc_q, req_pc_d;
    fifo_ent_t       mem_q [FIFO_DEPTH];
    fifo_ent_t       mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            req_fire;
    logic            push;
    logic            pop;

    // Issue is conservative: a pop in the same cycle does not free a slot
    // for a new request. The reset term keeps the bus quiet while rst is high.
    assign imem_req_valid = ~rst && (state_q == S_REQ) &&
                            (count_q < CW'(FIFO_DEPTH)) && ~redirect_valid;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign inst_valid = (count_q != '0);
    assign inst       = inst_valid ? mem_q[rd_ptr_q].inst : 32'd0;
    assign inst_addr  = inst_valid ? mem_q[rd_ptr_q].addr : 64'd0;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push     = 1'b0;
        pop      = inst_valid & id_ready;

        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    pc_d     = pc_q + 64'd4;
                    req_pc_d = pc_q;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    push    = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (redirect_valid) begin
            // Redirect wins over everything: flush, drop, restart.
            pc_d     = redirect_pc & ~64'd3;
            push     = 1'b0;
            pop      = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            // A response landing this very cycle retires the outstanding
            // request, so there is nothing left to drop afterward.
            if (state_q == S_REQ || imem_resp_valid) begin
                state_d = S_REQ;
            end else begin
                state_d = S_DROP;
            end
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{inst: imem_resp_data, addr: req_pc_q};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// ============================================================================
// tb_if_stage -- directed bench for if_stage. The bus and id_stage are driven
// by hand, cycle by cycle; inputs change 1 ns after a rising edge and outputs
// are checked 1 ns later, well away from the next edge.
// ============================================================================
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        id_ready;
    logic [31:0] inst;
    logic [63:0] inst_addr;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC  (64'h0000_0000_8000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .inst_valid     (inst_valid),
        .id_ready       (id_ready),
        .inst           (inst),
        .inst_addr      (inst_addr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resp(input logic v, input logic [31:0] d);
        imem_resp_valid = v;
        imem_resp_data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        id_ready        = 1'b0;
        #2;
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_inst_addr", inst_addr, 64'd0);
        step();

        // 1: first fetch after reset
        rst = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        chk("t1_req_valid", 64'(imem_req_valid), 64'd1);
        chk("t1_req_addr", imem_req_addr, 64'h8000_0000);
        step();                               // accept 0x80000000
        resp(1'b1, 32'h1111_1111);
        #1;
        chk("t1_wait_no_req", 64'(imem_req_valid), 64'd0);
        chk("t1_not_yet_valid", 64'(inst_valid), 64'd0);
        step();                               // push
        resp(1'b0, '0);
        #1;
        chk("t1_inst_valid", 64'(inst_valid), 64'd1);
        chk("t1_inst_addr", inst_addr, 64'h8000_0000);
        chk("t1_inst", 64'(inst), 64'h1111_1111);
        chk("t1_next_addr", imem_req_addr, 64'h8000_0004);
        chk("t1_next_valid", 64'(imem_req_valid), 64'd1);

        // 2: fill the FIFO while id_stage stalls
        step();                               // accept 0x80000004
        resp(1'b1, 32'h2222_2222);
        step();                               // push, count=2
        resp(1'b0, '0);
        #1;
        chk("t2_full_no_req", 64'(imem_req_valid), 64'd0);
        chk("t2_head_addr", inst_addr, 64'h8000_0000);
        step();
        chk("t2_full_hold", 64'(imem_req_valid), 64'd0);
        id_ready = 1'b1;
        #1;
        chk("t2_pop_no_issue", 64'(imem_req_valid), 64'd0);
        chk("t2_pop0_inst", 64'(inst), 64'h1111_1111);
        step();                               // pop entry 0
        chk("t2_head1_addr", inst_addr, 64'h8000_0004);
        chk("t2_head1_inst", 64'(inst), 64'h2222_2222);
        chk("t2_resume_valid", 64'(imem_req_valid), 64'd1);
        chk("t2_resume_addr", imem_req_addr, 64'h8000_0008);
        step();                               // pop entry 1, accept 0x80000008
        id_ready = 1'b0;
        resp(1'b1, 32'h3333_3333);
        #1;
        chk("t2_empty", 64'(inst_valid), 64'd0);
        chk("t2_empty_addr", inst_addr, 64'd0);
        step();
        resp(1'b0, '0);
        #1;
        chk("t2_third_addr", inst_addr, 64'h8000_0008);
        chk("t2_next_addr", imem_req_addr, 64'h8000_000C);

        // 3: redirect while waiting; the late response is discarded
        step();                               // accept 0x8000000C
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_1002;
        #1;
        chk("t3_redir_no_req", 64'(imem_req_valid), 64'd0);
        step();                               // flush, -> S_DROP
        redirect_valid = 1'b0;
        #1;
        chk("t3_flushed", 64'(inst_valid), 64'd0);
        chk("t3_drop_no_req", 64'(imem_req_valid), 64'd0);
        step();
        resp(1'b1, 32'hDEAD_BEEF);           // 3 cycles after accept
        step();                               // discarded
        resp(1'b0, '0);
        #1;
        chk("t3_discarded", 64'(inst_valid), 64'd0);
        chk("t3_req_valid", 64'(imem_req_valid), 64'd1);
        chk("t3_req_addr", imem_req_addr, 64'h8000_1000);
        step();                               // accept 0x80001000
        resp(1'b1, 32'h4444_4444);
        step();
        resp(1'b0, '0);
        #1;
        chk("t3_inst_addr", inst_addr, 64'h8000_1000);
        chk("t3_inst", 64'(inst), 64'h4444_4444);

        // 4: redirect coincides with a response and a pop
        step();                               // accept 0x80001004, count=1
        resp(1'b1, 32'h5A5A_5A5A);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_2000;
        id_ready       = 1'b1;
        step();
        resp(1'b0, '0);
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        #1;
        chk("t4_empty", 64'(inst_valid), 64'd0);
        chk("t4_inst_zero", 64'(inst), 64'd0);
        chk("t4_req_valid", 64'(imem_req_valid), 64'd1);
        chk("t4_req_addr", imem_req_addr, 64'h8000_2000);

        // 5: asynchronous reset with an entry queued and a request outstanding
        step();                               // accept 0x80002000
        resp(1'b1, 32'h5555_5555);
        step();
        resp(1'b0, '0);
        #1;
        chk("t5_queued", inst_addr, 64'h8000_2000);
        step();                               // accept 0x80002004, outstanding
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("t5_rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("t5_rst_inst_addr", inst_addr, 64'd0);
        #1;
        rst = 1'b0;
        #1;
        chk("t5_post_req_valid", 64'(imem_req_valid), 64'd1);
        chk("t5_post_req_addr", imem_req_addr, 64'h8000_0000);

        // 6: PC wrap at the top of the address space
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t6_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();                               // not ready: request held
        chk("t6_hold_valid", 64'(imem_req_valid), 64'd1);
        chk("t6_hold_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        imem_req_ready = 1'b1;
        step();                               // accept top address
        resp(1'b1, 32'h6666_6666);
        step();
        resp(1'b0, '0);
        imem_req_ready = 1'b0;
        #1;
        chk("t6_inst_addr", inst_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t6_inst", 64'(inst), 64'h6666_6666);
        chk("t6_wrap_addr", imem_req_addr, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
